// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// false-start rejection, parity/framing/overrun/break reporting, one-word hold register.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned M   = OVERSAMPLE / 2;
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_param: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, rxs_q;
  logic [CW-1:0]        div_q, div_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic                 v0_q, v0_d, v1_q, v1_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d, break_q, break_d;
  logic                 tick, at_mid, at_end, vote, done, ferr_now, accept;

  always_comb begin
    tick     = (div_q == CW'(DIV - 1));
    div_d    = tick ? '0 : div_q + 1'b1;
    at_mid   = tick && (scnt_q == SW'(M + 1));
    at_end   = tick && (scnt_q == SW'(OVERSAMPLE - 1));
    vote     = (v0_q & v1_q) | (v0_q & rxs_q) | (v1_q & rxs_q);
    ferr_now = ferr_q | ~vote;
    accept   = rx_valid_q && rx_ready;
    done     = 1'b0;

    state_d    = state_q;
    scnt_d     = scnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    zero_d     = zero_q;
    break_d    = 1'b0;

    if (tick) begin
      scnt_d = at_end ? '0 : scnt_q + 1'b1;
      if (scnt_q == SW'(M - 1)) v0_d = rxs_q;
      if (scnt_q == SW'(M))     v1_d = rxs_q;
    end

    case (state_q)
      S_IDLE: begin
        if (tick && !rxs_q) begin
          state_d    = S_START;
          scnt_d     = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          par_d      = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          zero_d     = 1'b1;
        end
      end
      S_START: begin
        if (at_mid && vote) state_d = S_IDLE;
        else if (at_end)    state_d = S_DATA;
      end
      S_DATA: begin
        if (at_mid) begin
          shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          par_d   = par_q ^ vote;
          zero_d  = zero_q & ~vote;
        end
        if (at_end) begin
          if (bit_idx_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (at_mid) begin
          zero_d = zero_q & ~vote;
          perr_d = (PARITY == 1) ? ~(par_q ^ vote) : (par_q ^ vote);
        end
        if (at_end) state_d = S_STOP;
      end
      S_STOP: begin
        // Break is judged on the first stop bit; completion on the last one.
        if (at_mid) begin
          ferr_d = ferr_now;
          if (!stop_idx_q && zero_q && !vote) begin
            state_d = S_BREAK;
            break_d = 1'b1;
          end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            done    = 1'b1;
          end
        end else if (at_end) begin
          stop_idx_d = 1'b1;
        end
      end
      S_BREAK: begin
        if (tick && rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (accept) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
    end
    if (done) begin
      if (!rx_valid_q || accept) begin
        rx_data_d    = shreg_q;
        rx_valid_d   = 1'b1;
        parity_err_d = perr_q;
        frame_err_d  = ferr_now;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      div_q        <= '0;
      scnt_q       <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      zero_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= rxd;
      rxs_q        <= sync1_q;
      div_q        <= div_d;
      scnt_q       <= scnt_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      zero_q       <= zero_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      break_q      <= break_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign break_det   = break_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 and an 8E1 receiver at 16 clk/bit, directed
// and random frames checked against a frame-level reference model.
module tb_uart_rx_param;

  localparam int unsigned BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd_n = 1'b1, rxd_e = 1'b1;
  logic       rdy_n = 1'b1, rdy_e = 1'b1;
  logic [7:0] data_n, data_e;
  logic       vld_n, vld_e, perr_n, perr_e, ferr_n, ferr_e;
  logic       ovr_n, ovr_e, brk_n, brk_e, busy_n, busy_e;

  int tests = 0;
  int fails = 0;
  int vcyc_n = 0, ovr_cnt_n = 0, brk_cnt_n = 0;
  int ovr_cnt_e = 0, brk_cnt_e = 0;
  logic [9:0] q_n[$];
  logic [9:0] q_e[$];

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_n (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_n), .rx_data(data_n), .rx_valid(vld_n),
    .rx_ready(rdy_n), .parity_err(perr_n), .frame_err(ferr_n), .overrun_err(ovr_n),
    .break_det(brk_n), .busy(busy_n)
  );

  uart_rx_param #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) u_e (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_e), .rx_data(data_e), .rx_valid(vld_e),
    .rx_ready(rdy_e), .parity_err(perr_e), .frame_err(ferr_e), .overrun_err(ovr_e),
    .break_det(brk_e), .busy(busy_e)
  );

  // Record every accepted word {parity_err, frame_err, data} and every pulse.
  always @(negedge clk) begin
    if (vld_n) vcyc_n++;
    if (vld_n && rdy_n) q_n.push_back({perr_n, ferr_n, data_n});
    if (vld_e && rdy_e) q_e.push_back({perr_e, ferr_e, data_e});
    if (ovr_n) ovr_cnt_n++;
    if (brk_n) brk_cnt_n++;
    if (ovr_e) ovr_cnt_e++;
    if (brk_e) brk_cnt_e++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input bit to_e, input logic v, input int unsigned clks);
    if (to_e) rxd_e = v; else rxd_n = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send(input bit to_e, input logic [7:0] d, input logic p, input logic stop);
    drive_bit(to_e, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(to_e, d[i], BIT_CLKS);
    if (to_e) drive_bit(to_e, p, BIT_CLKS);
    drive_bit(to_e, stop, BIT_CLKS);
    if (to_e) rxd_e = 1'b1; else rxd_n = 1'b1;
  endtask

  // Reference: word, parity error (even parity over data+p), framing error.
  function automatic logic [9:0] expect_word(input bit to_e, input logic [7:0] d,
                                             input logic p, input logic stop);
    logic pe;
    pe = to_e ? ^{d, p} : 1'b0;
    return {pe, ~stop, d};
  endfunction

  task automatic check_word(input string tag, input bit to_e, input logic [9:0] exp);
    logic [9:0] got;
    check({tag, "_count"}, to_e ? q_e.size() : q_n.size(), 1);
    got = '1;
    if (to_e && q_e.size() > 0) got = q_e.pop_front();
    if (!to_e && q_n.size() > 0) got = q_n.pop_front();
    check({tag, "_data"}, got[7:0], exp[7:0]);
    check({tag, "_ferr"}, got[8], exp[8]);
    check({tag, "_perr"}, got[9], exp[9]);
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s;
    bit         to_e;
    int         v0, o0, b0;

    repeat (4) @(negedge clk);
    check("reset_valid", {vld_n, vld_e}, 2'b00);
    check("reset_data", {data_n, data_e}, 16'h0000);
    check("reset_busy", {busy_n, busy_e}, 2'b00);
    check("reset_flags", {perr_n, ferr_n, ovr_n, brk_n, perr_e, ferr_e, ovr_e, brk_e}, 8'h00);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5, one valid cycle
    v0 = vcyc_n;
    send(1'b0, 8'hA5, 1'b0, 1'b1);
    repeat (24) @(negedge clk);
    check("a5_valid_cycles", vcyc_n - v0, 1);
    check_word("a5", 1'b0, expect_word(1'b0, 8'hA5, 1'b0, 1'b1));

    // 8E1 0x3C with bad and good parity bit
    send(1'b1, 8'h3C, 1'b1, 1'b1);
    repeat (24) @(negedge clk);
    check_word("3c_p1", 1'b1, {1'b1, 1'b0, 8'h3C});
    send(1'b1, 8'h3C, 1'b0, 1'b1);
    repeat (24) @(negedge clk);
    check_word("3c_p0", 1'b1, {1'b0, 1'b0, 8'h3C});

    // Stop bit forced low: framing error, not a break
    b0 = brk_cnt_n;
    send(1'b0, 8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check_word("55_stop0", 1'b0, {1'b0, 1'b1, 8'h55});
    check("55_no_break", brk_cnt_n - b0, 0);

    // Glitch of 4 clk: false start rejected within a bit time
    rxd_n = 1'b0;
    repeat (4) @(negedge clk);
    rxd_n = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_hi", busy_n, 1'b1);
    repeat (BIT_CLKS - 6) @(negedge clk);
    check("glitch_busy_lo", busy_n, 1'b0);
    check("glitch_no_word", q_n.size(), 0);

    // Random frames on both receivers
    for (int k = 0; k < 24; k++) begin
      to_e = k[0];
      d = 8'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      if (d == 8'h00) s = 1'b1;
      send(to_e, d, p, s);
      repeat (40) @(negedge clk);
      check_word("rand", to_e, expect_word(to_e, d, p, s));
    end
    check("rand_no_overrun", ovr_cnt_n + ovr_cnt_e, 0);
    check("rand_no_break", brk_cnt_n + brk_cnt_e, 0);

    // Overrun: consumer stalled across two back-to-back frames
    o0 = ovr_cnt_n;
    @(posedge clk); #2 rdy_n = 1'b0;
    @(negedge clk);
    send(1'b0, 8'h11, 1'b0, 1'b1);
    send(1'b0, 8'h22, 1'b0, 1'b1);
    repeat (24) @(negedge clk);
    check("ovr_pulses", ovr_cnt_n - o0, 1);
    check("ovr_held_data", data_n, 8'h11);
    check("ovr_held_valid", vld_n, 1'b1);
    @(posedge clk); #2 rdy_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_valid_drop", vld_n, 1'b0);
    check_word("ovr_word", 1'b0, {1'b0, 1'b0, 8'h11});

    // Break: line low for 30 bit times
    b0 = brk_cnt_n;
    drive_bit(1'b0, 1'b0, 30 * BIT_CLKS);
    drive_bit(1'b0, 1'b1, 40);
    check("break_pulses", brk_cnt_n - b0, 1);
    check("break_no_word", q_n.size(), 0);
    check("break_busy_lo", busy_n, 1'b0);

    // Asynchronous reset in the middle of a frame
    drive_bit(1'b0, 1'b0, 3 * BIT_CLKS);
    check("midframe_busy", busy_n, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {busy_n, busy_e}, 2'b00);
    check("arst_outputs", {vld_n, data_n, perr_n, ferr_n, ovr_n, brk_n}, 13'h0000);
    rxd_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
